add_sub_serial_param: RTL
=========================

Name: add_sub_serial_param

Overview:
Parametrised bit-serial adder/subtractor with valid/ready handshakes. It is the successor to the fixed 8-bit, 1-bit-per-cycle serial adder. Width and digit size (bits per cycle) are generic, and it adds a subtract mode plus carry-out and signed-overflow flags. It sits between datapath producers and consumers that tolerate multi-cycle latency in exchange for small area.

Parameters:
WIDTH, 8, operand/result width in bits; must be >= 2.
DIGIT, 1, bits processed per ADD cycle; must divide WIDTH exactly, 1 <= DIGIT <= WIDTH.
CNT_W, $clog2(WIDTH/DIGIT)+1, digit counter width; derived, not overridden.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous active-high reset.
in_valid  input  1  operands and mode valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
sub  input  1  0 = A+B, 1 = A-B.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
sum  output  WIDTH  result, two's complement.
cout  output  1  carry out of MSB (subtract: 1 = no borrow).
ovf  output  1  signed overflow.
busy  output  1  high in ADD or DONE.

Behaviour:
- Reset is synchronous, active-high, and sampled at the clk rising edge only. On reset: state=IDLE, sum=0, cout=0, ovf=0, out_valid=0, count=0, internal shift registers and carry cleared. Reset aborts any operation in flight; no result is emitted.
- The state machine has three states: IDLE, ADD, DONE.
- in_ready = (state==IDLE). busy = (state!=IDLE). out_valid = (state==DONE). All are decoded from registered state.
- IDLE: on in_valid at a clock edge, the block latches a into a_reg and (sub ? ~b : b) into b_reg, sets carry=sub, clears count and the result shift register, then goes to ADD. Without in_valid, it stays in IDLE.
- ADD, each cycle:
  - Takes the DIGIT LSBs of a_reg and b_reg plus carry.
  - Forms the DIGIT-bit sum and the new carry.
  - Shifts the digit into the result register from the MSB side.
  - Shifts a_reg and b_reg right by DIGIT.
  - Increments count.
  - On the last digit (count==WIDTH/DIGIT-1) it also captures cout = final carry and ovf = carry_into_MSB XOR carry_out_of_MSB, copies the completed result to sum, and goes to DONE.
- Latency: exactly N=WIDTH/DIGIT ADD cycles. out_valid is high in the cycle that begins N clock edges after the accepting edge. Example: WIDTH=8, DIGIT=1 gives 8 cycles.
- DONE: sum, cout and ovf are held stable. in_valid is ignored (in_ready=0). On out_valid && out_ready at an edge, the block goes to IDLE, and in_ready is high the following cycle. There is no same-cycle pass-through and no overlap, so peak throughput is one result per N+2 cycles.
- sum, cout and ovf keep their last values after DONE until the next completion or reset.
- Inputs a, b and sub are sampled only on the accepting edge. Changes to them during ADD or DONE have no effect.
- Arithmetic is modulo 2^WIDTH. Subtract is A + ~B + 1, so cout=1 means A>=B unsigned.
- Unused counter states: count never exceeds N-1. An illegal state encoding returns to IDLE on the next edge.

Test Plan:
- WIDTH=8, DIGIT=1: a=0x5A, b=0x33, sub=0 accepted -> after 8 cycles out_valid=1, sum=0x8D, cout=0, ovf=1.
- WIDTH=8, DIGIT=1: a=0x10, b=0x20, sub=1 -> sum=0xF0, cout=0, ovf=0. Then a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands -> out_valid and sum stay stable and in_ready stays 0. Release out_ready -> next cycle in_ready=1, and the new operands are accepted only then.
- Reset mid-operation: assert rst for 1 cycle at the 4th ADD cycle -> next cycle state IDLE, in_ready=1, sum=0, out_valid=0. A following 0x01+0x01 gives sum=0x02 with full 8-cycle latency.
- WIDTH=16, DIGIT=4: a=0x7FFF, b=0x0001, sub=0 -> out_valid after exactly 4 cycles, sum=0x8000, cout=0, ovf=1. Also a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- Input stability: change a, b and sub every cycle during ADD -> the result matches only the values sampled on the accepting edge.

Source files
------------

// File: rtl/add_sub_serial_param_if.sv
// add_sub_serial_param_if: operand/result handshake bundle for the serial adder/subtractor
interface add_sub_serial_param_if #(parameter int WIDTH = 8);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic sub;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] sum;
  logic cout;
  logic ovf;
  logic busy;
  modport master (output in_valid, a, b, sub, out_ready, input in_ready, out_valid, sum, cout, ovf, busy);
  modport slave (input in_valid, a, b, sub, out_ready, output in_ready, out_valid, sum, cout, ovf, busy);
endinterface

// File: rtl/add_sub_serial_param.sv
// add_sub_serial_param: digit-serial add/subtract with carry-out and signed overflow flags
module add_sub_serial_param #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1,
  localparam int N = WIDTH / DIGIT,
  localparam int CNT_W = $clog2(N) + 1
) (
  input logic clk,
  input logic rst,
  add_sub_serial_param_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg, res, res_nxt, sum;
  logic [CNT_W-1:0] count;
  logic carry, cout, ovf, last, msb_c;
  logic [DIGIT:0] dig;
  assign dig = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
  assign msb_c = a_reg[DIGIT-1] ^ b_reg[DIGIT-1] ^ dig[DIGIT-1];
  assign res_nxt = (WIDTH'(dig[DIGIT-1:0]) << (WIDTH - DIGIT)) | (res >> DIGIT);
  assign last = count == CNT_W'(N - 1);
  assign bus.in_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.sum = sum;
  assign bus.cout = cout;
  assign bus.ovf = ovf;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE ? (bus.in_valid ? ADD : IDLE) :
                state == ADD ? (last ? DONE : ADD) :
                state == DONE ? (bus.out_ready ? IDLE : DONE) : IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      res <= '0;
      carry <= 1'b0;
      count <= '0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      a_reg <= bus.a;
      b_reg <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.sub;
      count <= '0;
      res <= '0;
    end else if (state == ADD) begin
      a_reg <= a_reg >> DIGIT;
      b_reg <= b_reg >> DIGIT;
      carry <= dig[DIGIT];
      res <= res_nxt;
      count <= last ? '0 : count + CNT_W'(1);
      if (last) begin
        sum <= res_nxt;
        cout <= dig[DIGIT];
        ovf <= msb_c ^ dig[DIGIT];
      end
    end
endmodule
